// File: rtl/ahb_req_arbiter_pkg.sv
// ahb_arb_pkg: shared types and constants for the AHB request arbiter.
//   arb_state_t : arbiter FSM state (IDLE / IFU read / LSU read / LSU write)
//   ID_*        : read-id codes presented to the bus master
//   *_W         : widths of the starvation and timeout counters
package ahb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_IFU_RD = 2'd1,
    ST_LSU_RD = 2'd2,
    ST_LSU_WR = 2'd3
  } arb_state_t;

  localparam logic [1:0] ID_NONE = 2'b00;
  localparam logic [1:0] ID_IFU  = 2'b01;
  localparam logic [1:0] ID_LSU  = 2'b10;

  localparam int STARVE_W = 4;
  localparam int TMO_W    = 8;

endpackage

// File: rtl/ahb_req_arbiter.sv
// ahb_req_arbiter: shares one AHB bus master between the IFU (reads only)
// and the LSU (reads and writes). One transaction is outstanding at a time.
// Ports:
//   HCLK, HRESETn              clock, async active-low reset
//   ifu_req/ifu_addr           IFU read request        -> ifu_gnt, ifu_rvalid/ifu_rdata, ifu_err
//   lsu_req/we/addr/wdata/sel  LSU read/write request  -> lsu_gnt, lsu_rvalid/lsu_rdata, lsu_wdone, lsu_err
//   m_re/m_we/m_raddr/m_waddr/m_wdata/m_rsel/m_wsel/m_read_id   registered request to the master
//   m_rvalid_ifu/m_rvalid_lsu/m_wvalid/m_rdata                  completions from the master
// LSU has priority; the IFU wins once STARVE_MAX LSU grants have passed it.
// A transaction with no completion after TIMEOUT_CYC cycles is aborted.
module ahb_req_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned STARVE_MAX  = 4,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  input  logic                    ifu_req,
  input  logic [ADDR_WIDTH-1:0]   ifu_addr,
  output logic                    ifu_gnt,
  output logic                    ifu_rvalid,
  output logic [DATA_WIDTH-1:0]   ifu_rdata,
  output logic                    ifu_err,
  input  logic                    lsu_req,
  input  logic                    lsu_we,
  input  logic [ADDR_WIDTH-1:0]   lsu_addr,
  input  logic [DATA_WIDTH-1:0]   lsu_wdata,
  input  logic [DATA_WIDTH/8-1:0] lsu_sel,
  output logic                    lsu_gnt,
  output logic                    lsu_rvalid,
  output logic [DATA_WIDTH-1:0]   lsu_rdata,
  output logic                    lsu_wdone,
  output logic                    lsu_err,
  output logic                    m_re,
  output logic                    m_we,
  output logic [ADDR_WIDTH-1:0]   m_raddr,
  output logic [ADDR_WIDTH-1:0]   m_waddr,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_rsel,
  output logic [DATA_WIDTH/8-1:0] m_wsel,
  output logic [1:0]              m_read_id,
  input  logic                    m_rvalid_ifu,
  input  logic                    m_rvalid_lsu,
  input  logic                    m_wvalid,
  input  logic [DATA_WIDTH-1:0]   m_rdata
);

  localparam int unsigned SEL_WIDTH = DATA_WIDTH / 8;
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);
  // The counter is cleared on accept, so it holds TIMEOUT_CYC-1 in the
  // cycle whose increment would reach TIMEOUT_CYC.
  localparam logic [TMO_W-1:0]    TMO_LAST   = TMO_W'(TIMEOUT_CYC - 1);

  arb_state_t          state_r;
  arb_state_t          state_nxt_s;
  logic [STARVE_W-1:0] starve_r;
  logic [TMO_W-1:0]    tmo_r;
  logic                ifu_gnt_s;
  logic                lsu_gnt_s;
  logic                done_s;
  logic                tmo_hit_s;

  assign ifu_gnt = ifu_gnt_s;
  assign lsu_gnt = lsu_gnt_s;

  // Grant decision, completion matching, timeout detection and next state.
  always_comb begin
    ifu_gnt_s   = 1'b0;
    lsu_gnt_s   = 1'b0;
    done_s      = 1'b0;
    tmo_hit_s   = 1'b0;
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        lsu_gnt_s = lsu_req && !(ifu_req && (starve_r == STARVE_LIM));
        ifu_gnt_s = ifu_req && !lsu_gnt_s;
        if (lsu_gnt_s) begin
          state_nxt_s = lsu_we ? ST_LSU_WR : ST_LSU_RD;
        end else if (ifu_gnt_s) begin
          state_nxt_s = ST_IFU_RD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      // Only the completion belonging to the current transaction counts.
      ST_IFU_RD: done_s = m_rvalid_ifu;
      ST_LSU_RD: done_s = m_rvalid_lsu;
      ST_LSU_WR: done_s = m_wvalid;
      default:   state_nxt_s = ST_IDLE;
    endcase
    if (state_r != ST_IDLE) begin
      // A completion in the timeout cycle takes precedence over the abort.
      tmo_hit_s = !done_s && (tmo_r == TMO_LAST);
      if (done_s || tmo_hit_s) begin
        state_nxt_s = ST_IDLE;
      end else begin
        state_nxt_s = state_r;
      end
    end else begin
      tmo_hit_s = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // IFU anti-starvation and per-transaction timeout counters.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      starve_r <= 4'd0;
      tmo_r    <= 8'd0;
    end else begin
      if (lsu_gnt_s && ifu_req) begin
        starve_r <= (starve_r == STARVE_LIM) ? starve_r : starve_r + 4'd1;
      end else if (ifu_gnt_s) begin
        starve_r <= 4'd0;
      end else if ((state_r == ST_IDLE) && !ifu_req) begin
        starve_r <= 4'd0;
      end else begin
        starve_r <= starve_r;
      end
      if (ifu_gnt_s || lsu_gnt_s) begin
        tmo_r <= 8'd0;
      end else if (state_r != ST_IDLE) begin
        tmo_r <= tmo_r + 8'd1;
      end else begin
        tmo_r <= tmo_r;
      end
    end
  end

  // Registered master request and one-cycle responses to the requesters.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      m_re       <= 1'b0;
      m_we       <= 1'b0;
      m_raddr    <= '0;
      m_waddr    <= '0;
      m_wdata    <= '0;
      m_rsel     <= '0;
      m_wsel     <= '0;
      m_read_id  <= ID_NONE;
      ifu_rvalid <= 1'b0;
      ifu_rdata  <= '0;
      ifu_err    <= 1'b0;
      lsu_rvalid <= 1'b0;
      lsu_rdata  <= '0;
      lsu_wdone  <= 1'b0;
      lsu_err    <= 1'b0;
    end else begin
      ifu_rvalid <= 1'b0;
      ifu_err    <= 1'b0;
      lsu_rvalid <= 1'b0;
      lsu_wdone  <= 1'b0;
      lsu_err    <= 1'b0;

      if (lsu_gnt_s) begin
        m_re      <= !lsu_we;
        m_we      <= lsu_we;
        m_read_id <= lsu_we ? ID_NONE : ID_LSU;
        if (lsu_we) begin
          m_waddr <= lsu_addr;
          m_wdata <= lsu_wdata;
          m_wsel  <= lsu_sel;
        end else begin
          m_raddr <= lsu_addr;
          m_rsel  <= lsu_sel;
        end
      end else if (ifu_gnt_s) begin
        m_re      <= 1'b1;
        m_we      <= 1'b0;
        m_read_id <= ID_IFU;
        m_raddr   <= ifu_addr;
        m_rsel    <= {SEL_WIDTH{1'b1}};
      end else if (done_s || tmo_hit_s) begin
        m_re      <= 1'b0;
        m_we      <= 1'b0;
        m_read_id <= ID_NONE;
      end

      if (done_s) begin
        case (state_r)
          ST_IFU_RD: begin
            ifu_rvalid <= 1'b1;
            ifu_rdata  <= m_rdata;
          end
          ST_LSU_RD: begin
            lsu_rvalid <= 1'b1;
            lsu_rdata  <= m_rdata;
          end
          ST_LSU_WR: lsu_wdone <= 1'b1;
          default:   lsu_wdone <= 1'b0;
        endcase
      end

      if (tmo_hit_s) begin
        if (state_r == ST_IFU_RD) begin
          ifu_err <= 1'b1;
        end else begin
          lsu_err <= 1'b1;
        end
      end
    end
  end

endmodule
